mem_arbiter: RTL and testbench

Round-robin arbiter that shares one `mem` instance (one write port, one registered read port) between `NREQ` requesters. Each cycle it grants at most one write and at most one read, independently, and returns read data to the issuing requester with a one-hot response strobe. It resolves same-cycle write/read address collisions so that a read always observes every write granted before or alongside it. It sits between client blocks and the `mem` macro and drives all of the macro's inputs.

---
 rtl/mem_arbiter.sv | 137 +++++++++++++
 tb/tb_mem_arbiter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one mem (1 write port, 1 registered read port) among NREQ requesters.
// Latency: grants are combinational; read response arrives one cycle after the read grant.
// Backpressure: req_ready gates each requester; a same-address read is deferred one cycle behind a write.
module mem_arbiter #(
    parameter int NREQ  = 4,
    parameter int W     = 32,
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [NREQ-1:0]     req_we,
    input  logic [NREQ*AW-1:0]  req_addr,
    input  logic [NREQ*W-1:0]   req_wdata,
    output logic [NREQ-1:0]     req_ready,
    output logic [NREQ-1:0]     rsp_valid,
    output logic [W-1:0]        rsp_data,
    output logic                write,
    output logic [AW-1:0]       write_addr,
    output logic [W-1:0]        write_data,
    output logic [AW-1:0]       read_addr,
    input  logic [W-1:0]        read_data
);

    localparam int PW = $clog2(NREQ);

    logic [PW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
    logic            hold_q, hold_d;
    logic [AW-1:0]   write_addr_q, write_addr_d;
    logic [W-1:0]    write_data_q, write_data_d;
    logic [AW-1:0]   read_addr_q, read_addr_d;
    logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [NREQ-1:0] req_ready_c;

    logic [NREQ-1:0] w_elig, r_elig;
    logic            w_found, r_found;
    logic [PW-1:0]   w_idx, r_idx, w_try, r_try;
    logic [AW-1:0]   waddr_c, raddr_c;
    logic [W-1:0]    wdata_c;
    logic            wr_gnt, rd_cand, rd_gnt, coll;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(NREQ - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_elig = req_valid & req_we;
    assign r_elig = req_valid & ~req_we;

    // Pick the first eligible requester at or after each pointer, wrapping modulo NREQ.
    always_comb begin
        w_found = 1'b0;
        w_idx   = '0;
        w_try   = '0;
        r_found = 1'b0;
        r_idx   = '0;
        r_try   = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_try = PW'((int'(wptr_q) + k) % NREQ);
            if (!w_found && w_elig[w_try]) begin
                w_found = 1'b1;
                w_idx   = w_try;
            end
            r_try = PW'((int'(rptr_q) + k) % NREQ);
            if (!r_found && r_elig[r_try]) begin
                r_found = 1'b1;
                r_idx   = r_try;
            end
        end
    end

    assign waddr_c = req_addr[w_idx*AW +: AW];
    assign wdata_c = req_wdata[w_idx*W +: W];
    assign raddr_c = req_addr[r_idx*AW +: AW];

    // The write port is idle for one cycle after a collision so the deferred read always wins next.
    assign wr_gnt  = w_found & ~hold_q & ~rst;
    assign rd_cand = r_found & ~rst;
    // mem samples the read before the same-edge write, so a same-address read must wait a cycle.
    assign coll    = wr_gnt & rd_cand & (raddr_c == waddr_c);
    assign rd_gnt  = rd_cand & ~coll;

    // Next-state for pointers, held mem addresses/data, hold flag and response strobe.
    always_comb begin
        wptr_d       = wptr_q;
        rptr_d       = rptr_q;
        hold_d       = coll;
        write_addr_d = write_addr_q;
        write_data_d = write_data_q;
        read_addr_d  = read_addr_q;
        rsp_valid_d  = '0;
        req_ready_c  = '0;
        if (wr_gnt) begin
            wptr_d              = ptr_inc(w_idx);
            write_addr_d        = waddr_c;
            write_data_d        = wdata_c;
            req_ready_c[w_idx]  = 1'b1;
        end
        if (rd_gnt) begin
            rptr_d              = ptr_inc(r_idx);
            read_addr_d         = raddr_c;
            req_ready_c[r_idx]  = 1'b1;
            rsp_valid_d[r_idx]  = 1'b1;
        end
    end

    // State registers; reset also drops any read response in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q       <= '0;
            rptr_q       <= '0;
            hold_q       <= 1'b0;
            write_addr_q <= '0;
            write_data_q <= '0;
            read_addr_q  <= '0;
            rsp_valid_q  <= '0;
        end else begin
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            hold_q       <= hold_d;
            write_addr_q <= write_addr_d;
            write_data_q <= write_data_d;
            read_addr_q  <= read_addr_d;
            rsp_valid_q  <= rsp_valid_d;
        end
    end

    // Address/data go to mem in the grant cycle; idle cycles replay the last granted values.
    assign req_ready  = req_ready_c;
    assign write      = wr_gnt;
    assign write_addr = write_addr_d;
    assign write_data = write_data_d;
    assign read_addr  = read_addr_d;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = read_data;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural registered-read memory.
// Inputs change on the falling edge; outputs are sampled on the falling edge or 1 time unit later.
// Expected values are written by hand from the intended behaviour.
module tb_mem_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 32;
    localparam int AW   = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_we;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*W-1:0] req_wdata;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ-1:0]   rsp_valid;
    logic [W-1:0]      rsp_data;
    logic              write;
    logic [AW-1:0]     write_addr;
    logic [W-1:0]      write_data;
    logic [AW-1:0]     read_addr;
    logic [W-1:0]      read_data;

    logic [W-1:0]      mem_m [0:255];

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_data;

    mem_arbiter #(.NREQ(NREQ), .W(W), .DEPTH(256), .AW(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .write      (write),
        .write_addr (write_addr),
        .write_data (write_data),
        .read_addr  (read_addr),
        .read_data  (read_data)
    );

    always #5 clk = ~clk;

    // Registered read samples the array before this edge's write.
    always @(posedge clk) begin
        read_data <= mem_m[read_addr];
        if (write) mem_m[write_addr] <= write_data;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic we,
                           input logic [AW-1:0] a, input logic [W-1:0] d);
        req_valid[i]          = v;
        req_we[i]             = we;
        req_addr[i*AW +: AW]  = a;
        req_wdata[i*W +: W]   = d;
    endtask

    task automatic clear_reqs();
        req_valid = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
    endtask

    initial begin
        rst = 1'b1;
        clear_reqs();
        // Reset: everything requesting, nothing granted.
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 1'b1, AW'(100 + i), W'(32'hA0 + i));
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ready", 32'(req_ready), 32'h0);
        chk("rst_write", 32'(write), 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_write_addr", 32'(write_addr), 32'h0);
        chk("rst_read_addr", 32'(read_addr), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("first_grant", 32'(req_ready), 32'h1);
        chk("first_waddr", 32'(write_addr), 32'd100);

        // Write 42 to addr 4, then read it back from requester 1.
        @(negedge clk);
        clear_reqs();
        set_req(0, 1'b1, 1'b1, 8'd4, 32'd42);
        #1;
        chk("wr_ready", 32'(req_ready), 32'h1);
        chk("wr_write", 32'(write), 32'h1);
        chk("wr_addr", 32'(write_addr), 32'd4);
        chk("wr_data", 32'(write_data), 32'd42);
        @(negedge clk);
        clear_reqs();
        set_req(1, 1'b1, 1'b0, 8'd4, 32'd0);
        #1;
        chk("rd_ready", 32'(req_ready), 32'h2);
        chk("rd_addr", 32'(read_addr), 32'd4);
        @(negedge clk);
        chk("rd_rsp_valid", 32'(rsp_valid), 32'h2);
        chk("rd_rsp_data", 32'(rsp_data), 32'd42);
        clear_reqs();
        #1;
        chk("idle_write", 32'(write), 32'h0);
        chk("idle_waddr_hold", 32'(write_addr), 32'd4);
        chk("idle_raddr_hold", 32'(read_addr), 32'd4);
        @(negedge clk);
        chk("rsp_one_cycle", 32'(rsp_valid), 32'h0);

        // Collision: req0 writes 99 @20 while req2 reads @20; req3 write waits through hold.
        set_req(0, 1'b1, 1'b1, 8'd20, 32'd99);
        set_req(2, 1'b1, 1'b0, 8'd20, 32'd0);
        #1;
        chk("coll_ready", 32'(req_ready), 32'h1);
        chk("coll_write", 32'(write), 32'h1);
        @(negedge clk);
        set_req(0, 1'b0, 1'b0, 8'd0, 32'd0);
        set_req(3, 1'b1, 1'b1, 8'd30, 32'd77);
        #1;
        chk("hold_write", 32'(write), 32'h0);
        chk("hold_ready", 32'(req_ready), 32'h4);
        chk("hold_raddr", 32'(read_addr), 32'd20);
        @(negedge clk);
        chk("coll_rsp_valid", 32'(rsp_valid), 32'h4);
        chk("coll_rsp_data", 32'(rsp_data), 32'd99);
        set_req(2, 1'b0, 1'b0, 8'd0, 32'd0);
        #1;
        chk("post_hold_ready", 32'(req_ready), 32'h8);
        chk("post_hold_waddr", 32'(write_addr), 32'd30);

        // Round robin: all four write continuously; grant order 0,1,2,3,0,...
        @(negedge clk);
        clear_reqs();
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 1'b1, AW'((i == 3) ? 24 : 8 + 4 * i), W'(32'h100 * i));
        for (int c = 0; c < 8; c++) begin
            #1;
            chk($sformatf("rr_ready_%0d", c), 32'(req_ready), 32'(1 << (c % 4)));
            chk($sformatf("rr_waddr_%0d", c), 32'(write_addr), ((c % 4) == 3) ? 32'd24 : 32'(8 + 4 * (c % 4)));
            @(negedge clk);
            req_wdata[(c % 4)*W +: W] = W'(32'h100 * (c % 4) + c + 1);
            if (c == 3) begin
                // Data presented from here on is what each requester's later grant writes.
                for (int i = 0; i < NREQ; i++) req_wdata[i*W +: W] = W'(32'h100 * i + 4 + i);
            end
        end
        clear_reqs();
        for (int i = 0; i < NREQ; i++) begin
            set_req(i, 1'b1, 1'b0, AW'((i == 3) ? 24 : 8 + 4 * i), 32'd0);
            #1;
            chk($sformatf("rb_ready_%0d", i), 32'(req_ready), 32'(1 << i));
            @(negedge clk);
            exp_data = W'(32'h100 * i + 4 + i);
            chk($sformatf("rb_valid_%0d", i), 32'(rsp_valid), 32'(1 << i));
            chk($sformatf("rb_data_%0d", i), rsp_data, exp_data);
            clear_reqs();
        end

        // Parallel ports: preload 33 @8, then write 66 @16 alongside a read of @8.
        set_req(0, 1'b1, 1'b1, 8'd8, 32'd33);
        @(negedge clk);
        clear_reqs();
        set_req(1, 1'b1, 1'b1, 8'd16, 32'd66);
        set_req(3, 1'b1, 1'b0, 8'd8, 32'd0);
        #1;
        chk("par_ready", 32'(req_ready), 32'hA);
        chk("par_waddr", 32'(write_addr), 32'd16);
        chk("par_raddr", 32'(read_addr), 32'd8);
        @(negedge clk);
        chk("par_rsp_valid", 32'(rsp_valid), 32'h8);
        chk("par_rsp_data", 32'(rsp_data), 32'd33);
        clear_reqs();

        // Reset between a read grant and its response: response is dropped, pointers return to 0.
        @(negedge clk);
        set_req(2, 1'b1, 1'b0, 8'd16, 32'd0);
        #1;
        chk("mid_rd_ready", 32'(req_ready), 32'h4);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        clear_reqs();
        set_req(1, 1'b1, 1'b1, 8'd40, 32'd5);
        set_req(3, 1'b1, 1'b1, 8'd41, 32'd6);
        set_req(0, 1'b1, 1'b0, 8'd44, 32'd0);
        set_req(2, 1'b1, 1'b0, 8'd45, 32'd0);
        #1;
        chk("post_rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("post_rst_ptrs", 32'(req_ready), 32'h3);
        @(negedge clk);
        chk("post_rst_rsp", 32'(rsp_valid), 32'h1);
        clear_reqs();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
